// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 8-bit write-only LCD bus sequencer: power-up wait, fixed
// four-command init, then single-byte host writes with setup/enable/exec timing.
module lcd_cmd_sequencer #(
    parameter int PWRUP_CYCLES = 249999,
    parameter int SETUP_CYCLES = 2,
    parameter int E_CYCLES     = 12,
    parameter int CMD_CYCLES   = 2500,
    parameter int CLR_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_req,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam logic [2:0] S_PWRUP  = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_E_HIGH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_IDLE   = 3'd4;

    // Terminal counts: a state lasting N cycles leaves when the counter reads N-1.
    localparam logic [29:0] PWRUP_LAST = 30'(PWRUP_CYCLES - 1);
    localparam logic [29:0] SETUP_LAST = 30'(SETUP_CYCLES - 1);
    localparam logic [29:0] E_LAST     = 30'(E_CYCLES - 1);
    localparam logic [29:0] CMD_LAST   = 30'(CMD_CYCLES - 1);
    localparam logic [29:0] CLR_LAST   = 30'(CLR_CYCLES - 1);

    logic [2:0]  state;
    logic [29:0] cnt;
    logic [1:0]  init_idx;
    logic        slow_cmd;
    logic [29:0] wait_last;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Clear and home are the only commands needing the long execution wait.
    assign slow_cmd  = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
    assign wait_last = slow_cmd ? CLR_LAST : CMD_LAST;

    assign lcd_rw   = 1'b0;
    assign lcd_en   = (state == S_E_HIGH);
    assign wr_ready = (state == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is asynchronous, active-low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            cnt <= cnt + 30'd1;
            case (state)
                S_PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        state    <= S_SETUP;
                        cnt      <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_rom(init_idx);
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= S_E_HIGH;
                        cnt   <= '0;
                    end
                end
                S_E_HIGH: begin
                    if (cnt == E_LAST) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (init_done) begin
                            state <= S_IDLE;
                        end else if (init_idx == 2'd3) begin
                            state     <= S_IDLE;
                            init_done <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            init_idx <= init_idx + 2'd1;
                            lcd_rs   <= 1'b0;
                            lcd_data <= init_rom(init_idx + 2'd1);
                        end
                    end
                end
                S_IDLE: begin
                    cnt <= '0;
                    if (wr_req) begin
                        state    <= S_SETUP;
                        lcd_rs   <= wr_rs;
                        lcd_data <= wr_data;
                    end
                end
                default: begin
                    state <= S_PWRUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with short timing parameters
// (PWRUP=10, SETUP=2, E=3, CMD=5, CLR=20).
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_req;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    int checks = 0;
    int passed = 0;

    lcd_cmd_sequencer #(
        .PWRUP_CYCLES(10),
        .SETUP_CYCLES(2),
        .E_CYCLES    (3),
        .CMD_CYCLES  (5),
        .CLR_CYCLES  (20)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_req   (wr_req),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input logic level, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (lcd_en !== level && n < max);
    endtask

    task automatic wait_ready(input logic level, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (wr_ready !== level && n < max);
    endtask

    // Walks the init sequence from reset release; returns right after the
    // enable rise of pulse stop_at (0-based) if stop_at < 4.
    task automatic init_seq(input int stop_at);
        logic [7:0] rom [4];
        int n;
        int w;
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h06; rom[3] = 8'h01;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            wait_en(1'b1, 200, n);
            if (i == 0) check("pwrup_to_en", 32'(n), 12);
            else        check("en_spacing", 32'(w + n), 10);
            wr_req = 1'b0;
            check("init_data", 32'(lcd_data), 32'(rom[i]));
            check("init_rs", 32'(lcd_rs), 0);
            check("init_ready_low", 32'(wr_ready), 0);
            if (i == stop_at) return;
            wait_en(1'b0, 50, w);
            check("init_en_width", 32'(w), 3);
        end
        check("init_done_early", 32'(init_done), 0);
        wait_ready(1'b1, 200, n);
        check("init_final_wait", 32'(n), 20);
        check("init_done", 32'(init_done), 1);
    endtask

    task automatic host_write(input logic rs, input logic [7:0] d, input int exp_wait,
                              input bit poke);
        int n;
        check("ready_before_wr", 32'(wr_ready), 1);
        wr_req = 1'b1; wr_rs = rs; wr_data = d;
        tick();
        wr_req = 1'b0; wr_rs = ~rs; wr_data = 8'hFF;
        check("acc_rs", 32'(lcd_rs), 32'(rs));
        check("acc_data", 32'(lcd_data), 32'(d));
        check("acc_ready_low", 32'(wr_ready), 0);
        wait_en(1'b1, 50, n);
        check("wr_setup_len", 32'(n), 2);
        if (poke) begin
            wr_req = 1'b1; wr_rs = ~rs; wr_data = 8'h55;
        end
        wait_en(1'b0, 50, n);
        wr_req = 1'b0;
        check("wr_en_width", 32'(n), 3);
        check("wr_data_hold", 32'(lcd_data), 32'(d));
        wait_ready(1'b1, 100, n);
        check("wr_exec_wait", 32'(n), 32'(exp_wait));
    endtask

    initial begin
        int n;
        int highs;
        rstn = 1'b0; wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'hAA;
        #23;
        check("rst_en", 32'(lcd_en), 0);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_rw", 32'(lcd_rw), 0);
        check("rst_data", 32'(lcd_data), 0);
        check("rst_ready", 32'(wr_ready), 0);
        check("rst_init_done", 32'(init_done), 0);

        // Init with a host request held during power-up: it must be ignored.
        @(negedge clk); rstn = 1'b1;
        init_seq(4);
        check("idle_data_rom_last", 32'(lcd_data), 32'h01);

        host_write(1'b1, 8'h41, 5, 1'b0);

        // Home then set-address with wr_req held continuously.
        wr_req = 1'b1; wr_rs = 1'b0; wr_data = 8'h02;
        tick();
        check("b2b_first_data", 32'(lcd_data), 32'h02);
        wr_data = 8'h80;
        wait_en(1'b1, 50, n);
        check("b2b_setup", 32'(n), 2);
        check("b2b_ignored_data", 32'(lcd_data), 32'h02);
        wait_en(1'b0, 50, n);
        check("b2b_width", 32'(n), 3);
        wait_ready(1'b1, 100, n);
        check("b2b_home_wait", 32'(n), 20);
        tick();
        check("b2b_second_data", 32'(lcd_data), 32'h80);
        check("b2b_second_ready", 32'(wr_ready), 0);
        wr_req = 1'b0;
        wait_en(1'b1, 50, n);
        check("b2b_setup2", 32'(n), 2);
        wait_en(1'b0, 50, n);
        check("b2b_width2", 32'(n), 3);
        wait_ready(1'b1, 100, n);
        check("b2b_cmd_wait", 32'(n), 5);

        // Data byte 0x01 uses the short wait; request during E_HIGH is ignored.
        host_write(1'b1, 8'h01, 5, 1'b1);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lcd_en) highs++;
        end
        check("no_extra_pulse", 32'(highs), 0);
        check("idle_hold_data", 32'(lcd_data), 32'h01);
        check("idle_hold_rs", 32'(lcd_rs), 1);

        // Reset in the middle of the second init enable pulse.
        init_done_gate: begin
            rstn = 1'b0;
            #1;
            check("midrst_init_done", 32'(init_done), 0);
            @(negedge clk); rstn = 1'b1;
            init_seq(1);
            tick();
            check("midrst_en_before", 32'(lcd_en), 1);
            #2 rstn = 1'b0;
            #1;
            check("midrst_en", 32'(lcd_en), 0);
            check("midrst_data", 32'(lcd_data), 0);
            check("midrst_rs", 32'(lcd_rs), 0);
            check("midrst_ready", 32'(wr_ready), 0);
            check("midrst_done", 32'(init_done), 0);
            wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'hAA;
            @(negedge clk); rstn = 1'b1;
            init_seq(4);
            check("restart_idle_data", 32'(lcd_data), 32'h01);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
